// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end for the safe ALU.
// Optional halt-on-error behaviour is enabled by ALU_SEQ_HALT_ON_ERROR_EN.
module alu_cmd_sequencer #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_W-1:0]    cmd_a,
  input  logic [DATA_W-1:0]    cmd_b,
  input  logic [2:0]           cmd_op,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [2:0]           alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_result,
  output logic                 rsp_error,
  output logic [2:0]           rsp_op,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr,
  output logic                 halted,
  input  logic                 clear_halt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
    , ST_HALT
`endif
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_W-1:0]     alu_a_q;
  logic [DATA_W-1:0]     alu_b_q;
  logic [2:0]            alu_op_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_result_q;
  logic                  rsp_error_q;
  logic [2:0]            rsp_op_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d;
  logic                  capture;

  assign capture = (state_q == ST_DRIVE) && (cnt_q == 4'd0);

  // Saturating error count; a clear wins over a same-cycle increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (capture && alu_error && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  // Command sequencing FSM with registered ALU drive and response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_op_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a_q  <= cmd_a;
            alu_b_q  <= cmd_b;
            alu_op_q <= cmd_op;
            cnt_q    <= CNT_INIT;
            state_q  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_result;
            rsp_error_q  <= alu_error;
            rsp_op_q     <= alu_op_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
            state_q <= rsp_error_q ? ST_HALT : ST_IDLE;
`else
            state_q <= ST_IDLE;
`endif
          end
        end
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
        ST_HALT: begin
          if (clear_halt)
            state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is held low while reset is applied even though state is IDLE
  assign cmd_ready  = (state_q == ST_IDLE) && !rst;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_op     = rsp_op_q;
  assign err_count  = err_cnt_q;

`ifdef ALU_SEQ_HALT_ON_ERROR_EN
  assign halted = (state_q == ST_HALT);
`else
  logic unused_clear_halt;
  assign unused_clear_halt = clear_halt;
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of alu_cmd_sequencer.
// Two instances: SETTLE=1/ERR_CNT_W=2 and SETTLE=4/ERR_CNT_W=8.
module tb_alu_cmd_sequencer;

  logic clk;
  int   n_chk;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance A signals
  logic       rst_a, cmd_valid_a, cmd_ready_a;
  logic [7:0] cmd_a_a, cmd_b_a;
  logic [2:0] cmd_op_a;
  logic [7:0] alu_a_a, alu_b_a, alu_res_a;
  logic [2:0] alu_op_a;
  logic       alu_err_a;
  logic       rsp_valid_a, rsp_ready_a, rsp_error_a;
  logic [7:0] rsp_result_a;
  logic [2:0] rsp_op_a;
  logic [1:0] err_count_a;
  logic       err_clr_a, halted_a, clear_halt_a;

  // instance B signals
  logic       rst_b, cmd_valid_b, cmd_ready_b;
  logic [7:0] cmd_a_b, cmd_b_b;
  logic [2:0] cmd_op_b;
  logic [7:0] alu_a_b, alu_b_b, alu_res_b;
  logic [2:0] alu_op_b;
  logic       alu_err_b;
  logic       rsp_valid_b, rsp_ready_b, rsp_error_b;
  logic [7:0] rsp_result_b;
  logic [2:0] rsp_op_b;
  logic [7:0] err_count_b;
  logic       err_clr_b, halted_b, clear_halt_b;

  alu_cmd_sequencer #(
    .DATA_W(8), .SETTLE_CYCLES(1), .ERR_CNT_W(2)
  ) u_dut_a (
    .clk(clk), .rst(rst_a),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_a(cmd_a_a), .cmd_b(cmd_b_a), .cmd_op(cmd_op_a),
    .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_op(alu_op_a),
    .alu_result(alu_res_a), .alu_error(alu_err_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_result(rsp_result_a), .rsp_error(rsp_error_a),
    .rsp_op(rsp_op_a), .err_count(err_count_a),
    .err_clr(err_clr_a), .halted(halted_a),
    .clear_halt(clear_halt_a)
  );

  alu_cmd_sequencer #(
    .DATA_W(8), .SETTLE_CYCLES(4), .ERR_CNT_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_a(cmd_a_b), .cmd_b(cmd_b_b), .cmd_op(cmd_op_b),
    .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_op(alu_op_b),
    .alu_result(alu_res_b), .alu_error(alu_err_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_result(rsp_result_b), .rsp_error(rsp_error_b),
    .rsp_op(rsp_op_b), .err_count(err_count_b),
    .err_clr(err_clr_b), .halted(halted_b),
    .clear_halt(clear_halt_b)
  );

  // ALU stand-in: add, divide (zero divisor flags error), else xor
  function automatic logic [8:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    logic [8:0] r;
    r = {1'b0, a ^ b};
    if (op == 3'b000) r = {1'b0, a + b};
    if (op == 3'b100) r = (b == 8'd0) ? 9'h100 : {1'b0, a / b};
    return r;
  endfunction

  always_comb {alu_err_a, alu_res_a} = alu_f(alu_a_a, alu_b_a, alu_op_a);
  always_comb {alu_err_b, alu_res_b} = alu_f(alu_a_b, alu_b_b, alu_op_b);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one divide-by-zero command on A, optional err_clr at capture edge
  task automatic divzero_a(input logic clr, input logic [1:0] exp_cnt,
                           input string tag);
    cmd_a_a = 8'd5; cmd_b_a = 8'd0; cmd_op_a = 3'b100;
    cmd_valid_a = 1'b1; rsp_ready_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    err_clr_a = clr;
    tick();
    err_clr_a = 1'b0;
    chk({tag, "_err"}, {31'd0, rsp_error_a}, 32'd1);
    chk({tag, "_cnt"}, {30'd0, err_count_a}, {30'd0, exp_cnt});
    tick();
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
    clear_halt_a = 1'b1;
    tick();
    clear_halt_a = 1'b0;
`endif
  endtask

  int seen;

  initial begin
    n_chk = 0; n_bad = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    cmd_valid_a = 0; cmd_a_a = 0; cmd_b_a = 0; cmd_op_a = 0;
    rsp_ready_a = 0; err_clr_a = 0; clear_halt_a = 0;
    cmd_valid_b = 0; cmd_a_b = 0; cmd_b_b = 0; cmd_op_b = 0;
    rsp_ready_b = 0; err_clr_b = 0; clear_halt_b = 0;
    repeat (2) tick();

    chk("rst_ready", {31'd0, cmd_ready_a}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a_a}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("rst_err_cnt", {30'd0, err_count_a}, 32'd0);
    chk("rst_halted", {31'd0, halted_a}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready_a}, 32'd1);

    // add 10+2
    cmd_a_a = 8'd10; cmd_b_a = 8'd2; cmd_op_a = 3'b000;
    cmd_valid_a = 1'b1; rsp_ready_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    chk("add_ready_lo", {31'd0, cmd_ready_a}, 32'd0);
    chk("add_alu_a", {24'd0, alu_a_a}, 32'd10);
    chk("add_alu_b", {24'd0, alu_b_a}, 32'd2);
    chk("add_vld_e0", {31'd0, rsp_valid_a}, 32'd0);
    tick();
    chk("add_vld_e1", {31'd0, rsp_valid_a}, 32'd1);
    chk("add_res", {24'd0, rsp_result_a}, 32'd12);
    chk("add_err", {31'd0, rsp_error_a}, 32'd0);
    chk("add_op", {29'd0, rsp_op_a}, 32'd0);
    chk("add_cnt", {30'd0, err_count_a}, 32'd0);
    tick();
    chk("add_vld_hs", {31'd0, rsp_valid_a}, 32'd0);
    chk("add_ready_hs", {31'd0, cmd_ready_a}, 32'd1);

    // divide 10/2
    cmd_a_a = 8'd10; cmd_b_a = 8'd2; cmd_op_a = 3'b100;
    cmd_valid_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    chk("div_ready_e0", {31'd0, cmd_ready_a}, 32'd0);
    tick();
    chk("div_ready_e1", {31'd0, cmd_ready_a}, 32'd0);
    chk("div_res", {24'd0, rsp_result_a}, 32'd5);
    chk("div_err", {31'd0, rsp_error_a}, 32'd0);
    chk("div_op", {29'd0, rsp_op_a}, 32'd4);
    tick();
    chk("div_ready_hs", {31'd0, cmd_ready_a}, 32'd1);

    // pass-through opcode 011: 6^3
    cmd_a_a = 8'd6; cmd_b_a = 8'd3; cmd_op_a = 3'b011;
    cmd_valid_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    chk("pt_alu_op", {29'd0, alu_op_a}, 32'd3);
    tick();
    chk("pt_res", {24'd0, rsp_result_a}, 32'd5);
    chk("pt_op", {29'd0, rsp_op_a}, 32'd3);
    tick();

    // divide by zero
    cmd_a_a = 8'd10; cmd_b_a = 8'd0; cmd_op_a = 3'b100;
    cmd_valid_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    tick();
    chk("dz_err", {31'd0, rsp_error_a}, 32'd1);
    chk("dz_cnt", {30'd0, err_count_a}, 32'd1);
    tick();
    chk("dz_vld_hs", {31'd0, rsp_valid_a}, 32'd0);
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
    chk("dz_halted", {31'd0, halted_a}, 32'd1);
    chk("dz_ready_halt", {31'd0, cmd_ready_a}, 32'd0);
    tick();
    chk("dz_halt_hold", {31'd0, halted_a}, 32'd1);
    clear_halt_a = 1'b1;
    tick();
    clear_halt_a = 1'b0;
    chk("dz_unhalt", {31'd0, halted_a}, 32'd0);
    chk("dz_ready_clr", {31'd0, cmd_ready_a}, 32'd1);
`else
    chk("dz_halted", {31'd0, halted_a}, 32'd0);
    chk("dz_ready", {31'd0, cmd_ready_a}, 32'd1);
`endif

    // backpressure: 7+3 with rsp_ready low, cmd_valid left high
    cmd_a_a = 8'd7; cmd_b_a = 8'd3; cmd_op_a = 3'b000;
    cmd_valid_a = 1'b1; rsp_ready_a = 1'b0;
    tick();
    cmd_a_a = 8'd1; cmd_b_a = 8'd1;
    tick();
    chk("bp_vld", {31'd0, rsp_valid_a}, 32'd1);
    chk("bp_res", {24'd0, rsp_result_a}, 32'd10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", {31'd0, rsp_valid_a}, 32'd1);
      chk("bp_hold_res", {24'd0, rsp_result_a}, 32'd10);
      chk("bp_no_accept", {24'd0, alu_a_a}, 32'd7);
    end
    rsp_ready_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    chk("bp_vld_hs", {31'd0, rsp_valid_a}, 32'd0);
    chk("bp_ready_hs", {31'd0, cmd_ready_a}, 32'd1);

    // saturation with ERR_CNT_W=2, then clear vs increment
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    chk("clr_cnt", {30'd0, err_count_a}, 32'd0);
    divzero_a(1'b0, 2'd1, "sat1");
    divzero_a(1'b0, 2'd2, "sat2");
    divzero_a(1'b0, 2'd3, "sat3");
    divzero_a(1'b0, 2'd3, "sat4");
    divzero_a(1'b0, 2'd3, "sat5");
    divzero_a(1'b1, 2'd0, "clr_win");

    // instance B: SETTLE=4 timing, then reset mid-op
    cmd_a_b = 8'd9; cmd_b_b = 8'd0; cmd_op_b = 3'b100;
    cmd_valid_b = 1'b1; rsp_ready_b = 1'b1;
    tick();
    cmd_valid_b = 1'b0;
    repeat (3) tick();
    chk("b_vld_e3", {31'd0, rsp_valid_b}, 32'd0);
    tick();
    chk("b_vld_e4", {31'd0, rsp_valid_b}, 32'd1);
    chk("b_err", {31'd0, rsp_error_b}, 32'd1);
    chk("b_cnt", {24'd0, err_count_b}, 32'd1);
    tick();
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
    clear_halt_b = 1'b1;
    tick();
    clear_halt_b = 1'b0;
`endif
    chk("b_ready", {31'd0, cmd_ready_b}, 32'd1);

    cmd_a_b = 8'd20; cmd_b_b = 8'd5; cmd_op_b = 3'b000;
    cmd_valid_b = 1'b1;
    tick();
    cmd_valid_b = 1'b0;
    repeat (2) tick();
    chk("b_mid_alu_a", {24'd0, alu_a_b}, 32'd20);
    chk("b_mid_vld", {31'd0, rsp_valid_b}, 32'd0);
    rst_b = 1'b1;
    tick();
    chk("b_rst_vld", {31'd0, rsp_valid_b}, 32'd0);
    chk("b_rst_alu_a", {24'd0, alu_a_b}, 32'd0);
    chk("b_rst_alu_b", {24'd0, alu_b_b}, 32'd0);
    chk("b_rst_alu_op", {29'd0, alu_op_b}, 32'd0);
    chk("b_rst_cnt", {24'd0, err_count_b}, 32'd0);
    chk("b_rst_ready", {31'd0, cmd_ready_b}, 32'd0);
    rst_b = 1'b0;
    #1;
    chk("b_post_ready", {31'd0, cmd_ready_b}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid_b) seen++;
    end
    chk("b_no_rsp", seen, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
